// File: rtl/boot_uart_loader.sv
// UART boot-image loader: packs received bytes big-endian into 32-bit words,
// writes them to consecutive boot-memory addresses and validates a trailing XOR checksum.
module boot_uart_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int WORD_COUNT = 'h120
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  boot_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] boot_mem_addr,
    output logic [DATA_WIDTH-1:0] boot_mem_wr_data,
    output logic                  load_done,
    output logic                  load_error
);

    // WORD_COUNT may equal 2^ADDR_WIDTH, so only the last index is kept at address width.
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [7:0]            csum;
    logic                  rx_fire;
    logic                  start_ok;

    assign rx_fire = rx_valid & rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        start_ok         = 1'b0;
        rx_ready         = 1'b0;
        boot_mem_wr_en   = 1'b0;
        load_done        = 1'b0;
        load_error       = 1'b0;
        boot_mem_addr    = word_cnt;
        boot_mem_wr_data = word_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                rx_ready = 1'b1;
                if (rx_fire && byte_cnt == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                boot_mem_wr_en = 1'b1;
                state_next     = (word_cnt == LAST_WORD) ? CHECK : RECV;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    state_next = (rx_data == csum) ? DONE : ERROR;
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = RECV;
                end
            end
            ERROR: begin
                load_error = 1'b1;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The checksum byte itself is compared in CHECK and never folded into csum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            word_reg <= '0;
            csum     <= 8'd0;
        end else if (start_ok) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            word_reg <= '0;
            csum     <= 8'd0;
        end else begin
            if (state == RECV && rx_fire) begin
                word_reg <= {word_reg[DATA_WIDTH-9:0], rx_data};
                csum     <= csum ^ rx_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == WRITE && word_cnt != LAST_WORD) begin
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_boot_uart_loader.sv
// Bench for boot_uart_loader: three instances (WORD_COUNT 1, 2 and default) driven by
// table-driven image loads plus hand-written reset and full-size sequences.
module tb_boot_uart_loader;

    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]      start_v;
    logic [2:0]      rx_valid_v;
    logic [2:0][7:0] rx_data_v;
    wire  [2:0]      rx_ready_v;
    wire  [2:0]      wr_en_v;
    wire  [2:0]      done_v;
    wire  [2:0]      err_v;
    wire  [2:0][AW-1:0] addr_v;
    wire  [2:0][31:0]   wdata_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            d;
        logic [AW-1:0] a;
        logic [31:0]   w;
    } sb_t;

    typedef struct {
        int          d;
        int          nw;
        logic [63:0] words;
        logic [7:0]  cs;
        bit          done;
        bit          gaps;
    } vec_t;

    sb_t           exp_q[$];
    logic [31:0]   img_words[$];
    bit            gapless;
    bit            first_wr[3];
    int            last_cyc[3];
    int            nwrites[3];
    logic [AW-1:0] last_addr[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boot_uart_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WORD_COUNT(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .rx_valid(rx_valid_v[0]),
        .rx_data(rx_data_v[0]), .rx_ready(rx_ready_v[0]), .boot_mem_wr_en(wr_en_v[0]),
        .boot_mem_addr(addr_v[0]), .boot_mem_wr_data(wdata_v[0]),
        .load_done(done_v[0]), .load_error(err_v[0])
    );

    boot_uart_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WORD_COUNT(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .rx_valid(rx_valid_v[1]),
        .rx_data(rx_data_v[1]), .rx_ready(rx_ready_v[1]), .boot_mem_wr_en(wr_en_v[1]),
        .boot_mem_addr(addr_v[1]), .boot_mem_wr_data(wdata_v[1]),
        .load_done(done_v[1]), .load_error(err_v[1])
    );

    boot_uart_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) u_def (
        .clk(clk), .rst(rst), .start(start_v[2]), .rx_valid(rx_valid_v[2]),
        .rx_data(rx_data_v[2]), .rx_ready(rx_ready_v[2]), .boot_mem_wr_en(wr_en_v[2]),
        .boot_mem_addr(addr_v[2]), .boot_mem_wr_data(wdata_v[2]),
        .load_done(done_v[2]), .load_error(err_v[2])
    );

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check_eq("done_and_error_exclusive", {63'd0, done_v[d] & err_v[d]}, 64'd0);
            if (wr_en_v[d]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write_addr", {44'd0, addr_v[d]}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    sb_t e;
                    e = exp_q.pop_front();
                    check_eq("write_instance", d, e.d);
                    check_eq("write_addr", {44'd0, addr_v[d]}, {44'd0, e.a});
                    check_eq("write_data", {32'd0, wdata_v[d]}, {32'd0, e.w});
                end
                if (gapless && !first_wr[d]) begin
                    check_eq("write_spacing", cyc - last_cyc[d], 5);
                end
                first_wr[d]  = 1'b0;
                last_cyc[d]  = cyc;
                last_addr[d] = addr_v[d];
                nwrites[d]++;
            end
        end
    end

    // Entered and left on a falling edge; holds the byte until the handshake edge.
    task automatic send_byte(input int d, input logic [7:0] b, input bit gaps);
        int n   = 0;
        bit got = 1'b0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                rx_valid_v[d] = 1'b0;
                @(negedge clk);
            end
        end
        rx_valid_v[d] = 1'b1;
        rx_data_v[d]  = b;
        while (!got && n < 20) begin
            check_eq("ready_only_low_in_write", {63'd0, rx_ready_v[d]}, {63'd0, ~wr_en_v[d]});
            if (rx_ready_v[d]) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                n++;
            end
            @(negedge clk);
        end
        rx_valid_v[d] = 1'b0;
        if (!got) check_eq("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        check_eq("ready_after_start", {63'd0, rx_ready_v[d]}, 64'd1);
        check_eq("flags_after_start", {62'd0, done_v[d], err_v[d]}, 64'd0);
    endtask

    task automatic run_image(input int d, input logic [7:0] cs, input bit exp_done, input bit gaps);
        logic [31:0] w;
        for (int i = 0; i < img_words.size(); i++) begin
            exp_q.push_back('{d, AW'(i), img_words[i]});
        end
        gapless     = !gaps;
        first_wr[d] = 1'b1;
        nwrites[d]  = 0;
        pulse_start(d);
        for (int i = 0; i < img_words.size(); i++) begin
            w = img_words[i];
            send_byte(d, w[31:24], gaps);
            send_byte(d, w[23:16], gaps);
            send_byte(d, w[15:8],  gaps);
            send_byte(d, w[7:0],   gaps);
        end
        send_byte(d, cs, gaps);
        check_eq("load_done", {63'd0, done_v[d]}, {63'd0, exp_done});
        check_eq("load_error", {63'd0, err_v[d]}, {63'd0, !exp_done});
        check_eq("write_count", nwrites[d], img_words.size());
        check_eq("writes_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check_eq("result_held", {62'd0, done_v[d], err_v[d]}, {62'd0, exp_done, !exp_done});
    endtask

    function automatic logic [7:0] xor_image();
        logic [7:0] x = 8'd0;
        foreach (img_words[i]) begin
            x = x ^ img_words[i][31:24] ^ img_words[i][23:16] ^ img_words[i][15:8] ^ img_words[i][7:0];
        end
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{0, 1, {32'hDEADBEEF, 32'h0},        8'h22, 1'b1, 1'b0};
        tbl[1] = '{1, 2, {32'h00010203, 32'h04050607}, 8'h01, 1'b0, 1'b0};
        tbl[2] = '{1, 2, {32'h00010203, 32'h04050607}, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{1, 2, {32'hA55A3CC3, 32'h12345678}, 8'h08, 1'b1, 1'b1};
        tbl[4] = '{1, 2, {32'hA55A3CC3, 32'h12345678}, 8'h08, 1'b1, 1'b0};
        tbl[5] = '{0, 1, {32'h01020304, 32'h0},        8'h04, 1'b1, 1'b0};

        rst        = 1'b1;
        start_v    = '0;
        rx_valid_v = '0;
        rx_data_v  = '0;
        gapless    = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("reset_outputs",
                     {8'd0, rx_ready_v[d], wr_en_v[d], addr_v[d], wdata_v[d], done_v[d], err_v[d]}, 64'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            img_words.delete();
            img_words.push_back(tbl[k].words[63:32]);
            if (tbl[k].nw == 2) img_words.push_back(tbl[k].words[31:0]);
            run_image(tbl[k].d, tbl[k].cs, tbl[k].done, tbl[k].gaps);
        end

        // Reset after six bytes: word 0 is already written, the partial word 1 must vanish.
        exp_q.push_back('{1, AW'(0), 32'h00010203});
        gapless     = 1'b1;
        first_wr[1] = 1'b1;
        pulse_start(1);
        for (int i = 0; i < 6; i++) send_byte(1, 8'(i), 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midload_reset_outputs",
                 {8'd0, rx_ready_v[1], wr_en_v[1], addr_v[1], wdata_v[1], done_v[1], err_v[1]}, 64'd0);
        check_eq("midload_reset_clears_done", {63'd0, done_v[0]}, 64'd0);
        check_eq("midload_writes_before_reset", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        img_words.delete();
        img_words.push_back(32'h00010203);
        img_words.push_back(32'h04050607);
        run_image(1, 8'h00, 1'b1, 1'b0);

        // Full default-size image.
        img_words.delete();
        for (int i = 0; i < 'h120; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            img_words.push_back({iv[7:0], ~iv[7:0], 8'h5A ^ iv[15:8], iv[7:0] + 8'h33});
        end
        run_image(2, xor_image(), 1'b1, 1'b0);
        check_eq("default_last_addr", {44'd0, last_addr[2]}, 64'h11F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
